// File: rtl/retire_unit_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | retire_unit_pkg : shared types and constants for the retirement stage       |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package retire_unit_pkg;

  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;
  localparam int RD_W   = 5;

  typedef struct packed {
    logic              busy;
    logic              done;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
    logic              jump;
    logic [31:0]       target;
  } rob_entry_t;

endpackage
`default_nettype wire

// File: rtl/retire_unit_onehot_dec.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | onehot_dec : 5-to-32 one-hot decoder, register 0 never decodes              |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module onehot_dec #(
  parameter int LSB = 0
) (
  input  logic [4:0]     sel,
  output logic [31:LSB]  onehot
);

  // LSB lets a consumer that has no bit-0 lane drop it from the port entirely
  always_comb begin
    onehot = '0;
    for (int i = LSB; i < 32; i++) begin
      if (i != 0 && sel == 5'(i)) onehot[i] = 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/retire_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | retire_unit : in-order reorder buffer, register writeback and jump flush    |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module retire_unit
  import retire_unit_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int WIDTH = DATA_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     alloc_req,
  input  logic [4:0]               alloc_rd,
  output logic                     alloc_gnt,
  output logic [$clog2(DEPTH)-1:0] alloc_idx,
  input  logic                     res_valid,
  input  logic [$clog2(DEPTH)-1:0] res_idx,
  input  logic [WIDTH-1:0]         res_data,
  input  logic                     res_jump,
  input  logic [31:0]              res_target,
  output logic [31:1]              rf_we,
  output logic [WIDTH-1:0]         rf_data,
  output logic [31:0]              lock_release,
  output logic                     jump,
  output logic [31:0]              jump_target,
  output logic [TAG_W-1:0]         tag_out,
  output logic                     full,
  output logic                     empty
);

  localparam int IW = $clog2(DEPTH);

  logic [IW:0]      head;
  logic [IW:0]      tail;
  logic [TAG_W-1:0] tag;
  rob_entry_t       slots [DEPTH];

  logic [IW-1:0]    head_idx;
  logic [IW-1:0]    tail_idx;
  rob_entry_t       head_e;
  logic             commit;
  logic             flush;
  logic [31:1]      we_dec;
  logic [31:0]      rel_dec;

  assign head_idx = head[IW-1:0];
  assign tail_idx = tail[IW-1:0];
  assign head_e   = slots[head_idx];

  // Decoded from registered pointers only, so a same-cycle commit never frees a slot early
  assign full  = (head_idx == tail_idx) && (head[IW] != tail[IW]);
  assign empty = (head == tail);

  assign commit    = head_e.busy & head_e.done;
  assign flush     = commit & head_e.jump;
  assign alloc_gnt = alloc_req & ~full & ~flush;
  assign alloc_idx = tail_idx;
  assign tag_out   = tag;

  onehot_dec #(.LSB(1)) u_dec_we (
    .sel    (head_e.rd),
    .onehot (we_dec)
  );

  onehot_dec #(.LSB(0)) u_dec_rel (
    .sel    (head_e.rd),
    .onehot (rel_dec)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      tail <= '0;
      tag  <= '0;
      for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
    end else begin
      // Results for flushed or stale slots fail the busy test and vanish
      if (res_valid && slots[res_idx].busy && !flush) begin
        slots[res_idx].done   <= 1'b1;
        slots[res_idx].data   <= res_data;
        slots[res_idx].jump   <= res_jump;
        slots[res_idx].target <= res_target;
      end
      if (alloc_gnt) begin
        slots[tail_idx].busy <= 1'b1;
        slots[tail_idx].done <= 1'b0;
        slots[tail_idx].rd   <= alloc_rd;
        tail                 <= tail + 1'b1;
      end
      if (commit) begin
        slots[head_idx].busy <= 1'b0;
        head                 <= head + 1'b1;
      end
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) slots[i].busy <= 1'b0;
        tail <= head + 1'b1;
        tag  <= tag + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rf_we        <= '0;
      lock_release <= '0;
      rf_data      <= '0;
      jump         <= 1'b0;
      jump_target  <= '0;
    end else if (commit) begin
      rf_we        <= we_dec;
      lock_release <= rel_dec;
      rf_data      <= head_e.data;
      jump         <= head_e.jump;
      jump_target  <= head_e.target;
    end else begin
      rf_we        <= '0;
      lock_release <= '0;
      jump         <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_retire_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_retire_unit : directed self-checking bench for retire_unit               |
// | rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_retire_unit;

  logic        clk;
  logic        reset;
  logic        alloc_req;
  logic [4:0]  alloc_rd;
  logic        alloc_gnt;
  logic [2:0]  alloc_idx;
  logic        res_valid;
  logic [2:0]  res_idx;
  logic [31:0] res_data;
  logic        res_jump;
  logic [31:0] res_target;
  logic [31:1] rf_we;
  logic [31:0] rf_data;
  logic [31:0] lock_release;
  logic        jump;
  logic [31:0] jump_target;
  logic [3:0]  tag_out;
  logic        full;
  logic        empty;

  int n_total = 0;
  int n_bad   = 0;

  retire_unit #(.DEPTH(8), .WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .alloc_req    (alloc_req),
    .alloc_rd     (alloc_rd),
    .alloc_gnt    (alloc_gnt),
    .alloc_idx    (alloc_idx),
    .res_valid    (res_valid),
    .res_idx      (res_idx),
    .res_data     (res_data),
    .res_jump     (res_jump),
    .res_target   (res_target),
    .rf_we        (rf_we),
    .rf_data      (rf_data),
    .lock_release (lock_release),
    .jump         (jump),
    .jump_target  (jump_target),
    .tag_out      (tag_out),
    .full         (full),
    .empty        (empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset      = 1'b0;
    alloc_req  = 1'b0;
    alloc_rd   = '0;
    res_valid  = 1'b0;
    res_idx    = '0;
    res_data   = '0;
    res_jump   = 1'b0;
    res_target = '0;
    step();
    step();
    reset = 1'b1;
    #1;
  endtask

  task automatic alloc(input logic [4:0] rd, input logic [2:0] exp_idx, input string tag);
    alloc_req = 1'b1;
    alloc_rd  = rd;
    #1;
    check_eq({tag, "_gnt"}, 64'(alloc_gnt), 64'd1);
    check_eq({tag, "_idx"}, 64'(alloc_idx), 64'(exp_idx));
    step();
    alloc_req = 1'b0;
  endtask

  task automatic result(input logic [2:0] idx, input logic [31:0] data,
                        input logic jmp, input logic [31:0] target);
    res_valid  = 1'b1;
    res_idx    = idx;
    res_data   = data;
    res_jump   = jmp;
    res_target = target;
    step();
    res_valid  = 1'b0;
    res_jump   = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, "_empty"}, 64'(empty), 64'd1);
    check_eq({tag, "_full"},  64'(full),  64'd0);
    check_eq({tag, "_tag"},   64'(tag_out), 64'd0);
    check_eq({tag, "_we"},    64'({rf_we, 1'b0}), 64'd0);
    check_eq({tag, "_rel"},   64'(lock_release), 64'd0);
    check_eq({tag, "_jump"},  64'(jump), 64'd0);
    check_eq({tag, "_idx"},   64'(alloc_idx), 64'd0);
    check_eq({tag, "_data"},  64'(rf_data), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] e;

    do_reset();
    check_reset_state("rst0");

    // In-order flow
    alloc(5'd5, 3'd0, "io_a0");
    alloc(5'd6, 3'd1, "io_a1");
    alloc(5'd7, 3'd2, "io_a2");
    result(3'd0, 32'h11, 1'b0, 32'h0);
    check_eq("io_none", 64'({rf_we, 1'b0}), 64'd0);
    result(3'd1, 32'h22, 1'b0, 32'h0);
    check_eq("io_we0",  64'({rf_we, 1'b0}), 64'h20);
    check_eq("io_d0",   64'(rf_data), 64'h11);
    check_eq("io_rel0", 64'(lock_release), 64'h20);
    result(3'd2, 32'h33, 1'b0, 32'h0);
    check_eq("io_we1",  64'({rf_we, 1'b0}), 64'h40);
    check_eq("io_d1",   64'(rf_data), 64'h22);
    check_eq("io_rel1", 64'(lock_release), 64'h40);
    step();
    check_eq("io_we2",  64'({rf_we, 1'b0}), 64'h80);
    check_eq("io_d2",   64'(rf_data), 64'h33);
    check_eq("io_rel2", 64'(lock_release), 64'h80);
    step();
    check_eq("io_idle", 64'({rf_we, 1'b0}), 64'd0);
    check_eq("io_empty", 64'(empty), 64'd1);

    // Out-of-order arrival: nothing retires until slot 0 completes
    do_reset();
    alloc(5'd8,  3'd0, "oo_a0");
    alloc(5'd9,  3'd1, "oo_a1");
    alloc(5'd10, 3'd2, "oo_a2");
    alloc(5'd11, 3'd3, "oo_a3");
    result(3'd3, 32'hD3, 1'b0, 32'h0);
    check_eq("oo_w3", 64'({rf_we, 1'b0}), 64'd0);
    result(3'd1, 32'hD1, 1'b0, 32'h0);
    check_eq("oo_w1", 64'({rf_we, 1'b0}), 64'd0);
    result(3'd2, 32'hD2, 1'b0, 32'h0);
    check_eq("oo_w2", 64'({rf_we, 1'b0}), 64'd0);
    result(3'd0, 32'hD0, 1'b0, 32'h0);
    check_eq("oo_w0", 64'({rf_we, 1'b0}), 64'd0);
    step();
    check_eq("oo_c0_we", 64'({rf_we, 1'b0}), 64'h100);
    check_eq("oo_c0_d",  64'(rf_data), 64'hD0);
    step();
    check_eq("oo_c1_we", 64'({rf_we, 1'b0}), 64'h200);
    check_eq("oo_c1_d",  64'(rf_data), 64'hD1);
    step();
    check_eq("oo_c2_we", 64'({rf_we, 1'b0}), 64'h400);
    check_eq("oo_c2_d",  64'(rf_data), 64'hD2);
    step();
    check_eq("oo_c3_we", 64'({rf_we, 1'b0}), 64'h800);
    check_eq("oo_c3_d",  64'(rf_data), 64'hD3);
    step();
    check_eq("oo_idle", 64'({rf_we, 1'b0}), 64'd0);
    check_eq("oo_empty", 64'(empty), 64'd1);

    // Full boundary and pointer wrap
    do_reset();
    for (int i = 0; i < 8; i++) alloc(5'(i + 1), 3'(i), "fu_a");
    alloc_req = 1'b1;
    alloc_rd  = 5'd12;
    res_valid = 1'b1;
    res_idx   = 3'd0;
    res_data  = 32'h55;
    #1;
    check_eq("fu_full",  64'(full), 64'd1);
    check_eq("fu_gnt9",  64'(alloc_gnt), 64'd0);
    step();
    res_valid = 1'b0;
    #1;
    check_eq("fu_full_commit", 64'(full), 64'd1);
    check_eq("fu_gnt_commit",  64'(alloc_gnt), 64'd0);
    step();
    check_eq("fu_c_we",   64'({rf_we, 1'b0}), 64'h2);
    check_eq("fu_c_d",    64'(rf_data), 64'h55);
    check_eq("fu_free",   64'(full), 64'd0);
    check_eq("fu_gnt",    64'(alloc_gnt), 64'd1);
    check_eq("fu_idx",    64'(alloc_idx), 64'd0);
    step();
    alloc_req = 1'b0;
    #1;
    check_eq("fu_wrap_full", 64'(full), 64'd1);

    // Jump flush
    do_reset();
    alloc(5'd1, 3'd0, "jf_a0");
    alloc(5'd2, 3'd1, "jf_a1");
    alloc(5'd3, 3'd2, "jf_a2");
    result(3'd1, 32'hAA, 1'b0, 32'h0);
    check_eq("jf_w1", 64'({rf_we, 1'b0}), 64'd0);
    result(3'd2, 32'hBB, 1'b0, 32'h0);
    check_eq("jf_w2", 64'({rf_we, 1'b0}), 64'd0);
    result(3'd0, 32'hCC, 1'b1, 32'h100);
    check_eq("jf_w0",    64'({rf_we, 1'b0}), 64'd0);
    check_eq("jf_tag0",  64'(tag_out), 64'd0);
    check_eq("jf_busy",  64'(empty), 64'd0);
    step();
    check_eq("jf_we",    64'({rf_we, 1'b0}), 64'h2);
    check_eq("jf_d",     64'(rf_data), 64'hCC);
    check_eq("jf_jump",  64'(jump), 64'd1);
    check_eq("jf_tgt",   64'(jump_target), 64'h100);
    check_eq("jf_tag1",  64'(tag_out), 64'd1);
    check_eq("jf_empty", 64'(empty), 64'd1);
    result(3'd1, 32'hDD, 1'b0, 32'h0);
    check_eq("jf_pulse_end", 64'(jump), 64'd0);
    check_eq("jf_late1", 64'({rf_we, 1'b0}), 64'd0);
    result(3'd2, 32'hEE, 1'b0, 32'h0);
    check_eq("jf_late2", 64'({rf_we, 1'b0}), 64'd0);
    step();
    check_eq("jf_late3", 64'({rf_we, 1'b0}), 64'd0);
    check_eq("jf_still_empty", 64'(empty), 64'd1);
    alloc(5'd4, 3'd1, "jf_next");

    // rd = 0 commits without writeback
    do_reset();
    alloc(5'd0, 3'd0, "r0_a");
    result(3'd0, 32'h77, 1'b0, 32'h0);
    step();
    check_eq("r0_we",    64'({rf_we, 1'b0}), 64'd0);
    check_eq("r0_rel",   64'(lock_release), 64'd0);
    check_eq("r0_data",  64'(rf_data), 64'h77);
    check_eq("r0_empty", 64'(empty), 64'd1);

    // Sixteen jump commits wrap the tag back to zero
    do_reset();
    e = 3'd0;
    for (int i = 1; i <= 16; i++) begin
      alloc(5'd0, e, "tw_a");
      result(e, 32'(i), 1'b1, 32'h200 + 32'(i));
      step();
      check_eq("tw_jump", 64'(jump), 64'd1);
      check_eq("tw_tgt",  64'(jump_target), 64'h200 + 64'(i));
      check_eq("tw_tag",  64'(tag_out), 64'(i % 16));
      e = e + 3'd1;
    end
    check_eq("tw_wrapped", 64'(tag_out), 64'd0);

    // Reset asserted mid-run with a non-zero tag and an occupied slot
    alloc(5'd9, e, "mr_a0");
    result(e, 32'h99, 1'b1, 32'h300);
    step();
    check_eq("mr_tag1", 64'(tag_out), 64'd1);
    alloc(5'd10, e + 3'd1, "mr_a1");
    do_reset();
    check_reset_state("rst_mid");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
